// File: rtl/feature_mask_counter.sv
// feature_mask_counter
//   Thresholds a full-resolution 8-bit pixel stream into a feature mask,
//   tracks raster position and counts feature pixels per frame. Every output
//   is registered on the edge that accepts its pixel, so the pixel path has a
//   latency of one cycle and frame_done rises together with the last pixel's
//   validout.
//
//   Build option: FEATURE_OVERLAY_EN
//     defined   : below-threshold pixels pass through unchanged, features
//                 are painted white (8'hFF) over the image.
//     undefined : pure binary mask (8'h00 / 8'hFF).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | after reset, waiting for the first valid pixel or frame_sync
//   ACTIVE | streaming a frame
//   DONE   | one cycle after the last pixel: count latched, frame_done
//          | high, raster back at (0,0); a valid pixel here starts the
//          | next frame

module feature_mask_counter #(
   parameter int COLS  = 800,
   parameter int ROWS  = 600,
   parameter int CNT_W = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       din,
   input  logic             valid,
   input  logic             frame_sync,
   input  logic [7:0]       threshold,
   output logic [7:0]       dout,
   output logic             validout,
   output logic [9:0]       rowcount,
   output logic [9:0]       colcount,
   output logic [CNT_W-1:0] feature_count,
   output logic             frame_done
);

   localparam logic [9:0]       LAST_COL = 10'(COLS - 1);
   localparam logic [9:0]       LAST_ROW = 10'(ROWS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t           state_q, state_d;
   logic [9:0]       row_q, col_q, row_d, col_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic [7:0]       thr_q, thr_d;

   logic [9:0]       pos_row, pos_col;
   logic             first_pix;
   logic [7:0]       thr_eff;
   logic             over_thr;
   logic             hit;
   logic             last_pix;
   logic [CNT_W-1:0] run_base, run_inc;
   logic [7:0]       mask_pix;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, raster position, threshold sampling and running count.
   always_comb begin
      // frame_sync rebases the current cycle's pixel to (0,0) of a new frame
      pos_row   = frame_sync ? 10'd0 : row_q;
      pos_col   = frame_sync ? 10'd0 : col_q;
      first_pix = (pos_row == 10'd0) && (pos_col == 10'd0);
      // the (0,0) pixel compares against the value being sampled, not thr_q
      thr_eff   = first_pix ? threshold : thr_q;
      over_thr  = (din >= thr_eff);
      hit       = valid && over_thr;
      last_pix  = valid && !frame_sync &&
                  (pos_row == LAST_ROW) && (pos_col == LAST_COL);
      run_base  = frame_sync ? '0 : run_q;
      run_inc   = (hit && (run_base != CNT_MAX)) ? run_base + 1'b1 : run_base;

      row_d   = pos_row;
      col_d   = pos_col;
      run_d   = run_base;
      thr_d   = thr_q;
      state_d = state_q;

      if (valid) begin
         if (first_pix) thr_d = threshold;
         if (pos_col == LAST_COL) begin
            col_d = 10'd0;
            row_d = (pos_row == LAST_ROW) ? 10'd0 : pos_row + 10'd1;
         end else begin
            col_d = pos_col + 10'd1;
         end
         run_d = last_pix ? '0 : run_inc;
      end

      case (state_q)
         IDLE:    if (valid) state_d = ACTIVE;
         ACTIVE:  if (last_pix) state_d = DONE;
         DONE:    state_d = last_pix ? DONE : ACTIVE;
         default: state_d = IDLE;
      endcase
      // a frame_sync never completes a frame (last_pix is already masked)
      if (frame_sync && !last_pix) state_d = ACTIVE;
   end

   // Mask pixel generation.
   always_comb begin
`ifdef FEATURE_OVERLAY_EN
      mask_pix = over_thr ? 8'hFF : din;
`else
      mask_pix = over_thr ? 8'hFF : 8'h00;
`endif
   end

   // Raster, threshold and running-count registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
         run_q <= '0;
         thr_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         run_q <= run_d;
         thr_q <= thr_d;
      end
   end

   // Output registers; pixel outputs hold while no pixel is accepted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dout          <= '0;
         validout      <= 1'b0;
         rowcount      <= '0;
         colcount      <= '0;
         feature_count <= '0;
         frame_done    <= 1'b0;
      end else begin
         validout   <= valid;
         frame_done <= last_pix;
         if (valid) begin
            dout     <= mask_pix;
            rowcount <= pos_row;
            colcount <= pos_col;
         end
         if (last_pix) feature_count <= run_inc;
      end
   end

endmodule

// File: tb/tb_feature_mask_counter.sv
// Directed bench for feature_mask_counter on a 4x3 raster. A second instance
// with a 3-bit counter sees the same stimulus to exercise saturation.

module tb_feature_mask_counter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  din = '0;
   logic        valid = 1'b0;
   logic        frame_sync = 1'b0;
   logic [7:0]  threshold = '0;

   logic [7:0]  dout;
   logic        validout;
   logic [9:0]  rowcount, colcount;
   logic [19:0] feature_count;
   logic        frame_done;

   logic [7:0]  dout_s;
   logic        validout_s;
   logic [9:0]  rowcount_s, colcount_s;
   logic [2:0]  feature_count_s;
   logic        frame_done_s;

   int total = 0;
   int bad   = 0;
   int exp_fc = 0;
   int exp_fc_s = 0;
   logic [7:0] last_dout = '0;

   always #5 clock = ~clock;

   feature_mask_counter #(.COLS(4), .ROWS(3), .CNT_W(20)) dut (
      .clock(clock), .reset(reset), .din(din), .valid(valid),
      .frame_sync(frame_sync), .threshold(threshold), .dout(dout),
      .validout(validout), .rowcount(rowcount), .colcount(colcount),
      .feature_count(feature_count), .frame_done(frame_done)
   );

   feature_mask_counter #(.COLS(4), .ROWS(3), .CNT_W(3)) dut_sat (
      .clock(clock), .reset(reset), .din(din), .valid(valid),
      .frame_sync(frame_sync), .threshold(threshold), .dout(dout_s),
      .validout(validout_s), .rowcount(rowcount_s), .colcount(colcount_s),
      .feature_count(feature_count_s), .frame_done(frame_done_s)
   );

   // One valid pixel; outputs are checked #1 after the accepting edge.
   task automatic send(input logic [7:0] pix, input logic [7:0] thr,
                       input logic sync, input int er, input int ec,
                       input logic eh, input logic ed,
                       input int ecnt, input int esat);
      logic [7:0] ed_out;
      @(negedge clock);
      din = pix; threshold = thr; valid = 1'b1; frame_sync = sync;
      @(posedge clock); #1;
`ifdef FEATURE_OVERLAY_EN
      ed_out = eh ? 8'hFF : pix;
`else
      ed_out = eh ? 8'hFF : 8'h00;
`endif
      if (ed) begin exp_fc = ecnt; exp_fc_s = esat; end
      total += 7;
      if (validout !== 1'b1) begin bad++; $display("FAIL validout got=%0b want=1", validout); end
      if (dout !== ed_out) begin bad++; $display("FAIL dout (%0d,%0d) got=%h want=%h", er, ec, dout, ed_out); end
      if (rowcount !== 10'(er)) begin bad++; $display("FAIL rowcount got=%0d want=%0d", rowcount, er); end
      if (colcount !== 10'(ec)) begin bad++; $display("FAIL colcount got=%0d want=%0d", colcount, ec); end
      if (frame_done !== ed) begin bad++; $display("FAIL frame_done (%0d,%0d) got=%0b want=%0b", er, ec, frame_done, ed); end
      if (feature_count !== 20'(exp_fc)) begin bad++; $display("FAIL feature_count got=%0d want=%0d", feature_count, exp_fc); end
      if (feature_count_s !== 3'(exp_fc_s)) begin bad++; $display("FAIL feature_count_sat got=%0d want=%0d", feature_count_s, exp_fc_s); end
      last_dout = ed_out;
   endtask

   // Idle cycles: outputs must hold and no frame_done may appear.
   task automatic idle(input int n, input int er, input int ec);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         valid = 1'b0; frame_sync = 1'b0;
         @(posedge clock); #1;
         total += 6;
         if (validout !== 1'b0) begin bad++; $display("FAIL idle_validout got=%0b want=0", validout); end
         if (frame_done !== 1'b0) begin bad++; $display("FAIL idle_frame_done got=%0b want=0", frame_done); end
         if (rowcount !== 10'(er)) begin bad++; $display("FAIL idle_rowcount got=%0d want=%0d", rowcount, er); end
         if (colcount !== 10'(ec)) begin bad++; $display("FAIL idle_colcount got=%0d want=%0d", colcount, ec); end
         if (dout !== last_dout) begin bad++; $display("FAIL idle_dout got=%h want=%h", dout, last_dout); end
         if (feature_count !== 20'(exp_fc)) begin bad++; $display("FAIL idle_feature_count got=%0d want=%0d", feature_count, exp_fc); end
      end
   endtask

   task automatic check_zero(input string tag);
      total += 7;
      if (dout !== 8'h00) begin bad++; $display("FAIL %s dout got=%h want=00", tag, dout); end
      if (validout !== 1'b0) begin bad++; $display("FAIL %s validout got=%0b want=0", tag, validout); end
      if (rowcount !== 10'd0) begin bad++; $display("FAIL %s rowcount got=%0d want=0", tag, rowcount); end
      if (colcount !== 10'd0) begin bad++; $display("FAIL %s colcount got=%0d want=0", tag, colcount); end
      if (feature_count !== 20'd0) begin bad++; $display("FAIL %s feature_count got=%0d want=0", tag, feature_count); end
      if (frame_done !== 1'b0) begin bad++; $display("FAIL %s frame_done got=%0b want=0", tag, frame_done); end
      if (feature_count_s !== 3'd0) begin bad++; $display("FAIL %s feature_count_sat got=%0d want=0", tag, feature_count_s); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_zero("reset");
      @(negedge clock);
      reset = 1'b0;
   endtask

   // 0x00..0xB0 against 0x80: pixels 8..11 are features, count 4.
   task automatic test_basic();
      for (int i = 0; i < 12; i++)
         send(8'(i * 16), 8'h80, 1'b0, i / 4, i % 4, i >= 8, i == 11, 4, 4);
      idle(1, 2, 3);
   endtask

   task automatic test_gapped();
      for (int i = 0; i < 12; i++) begin
         send(8'(i * 16), 8'h80, 1'b0, i / 4, i % 4, i >= 8, i == 11, 4, 4);
         idle(2, i / 4, i % 4);
      end
   endtask

   // Threshold drops to 0 at pixel 5: this frame keeps 0x80, next frame sees 0.
   task automatic test_threshold_change();
      for (int i = 0; i < 12; i++)
         send(8'(i * 16), (i < 5) ? 8'h80 : 8'h00, 1'b0, i / 4, i % 4,
              i >= 8, i == 11, 4, 4);
      for (int i = 0; i < 12; i++)
         send(8'(i * 16), 8'h00, 1'b0, i / 4, i % 4, 1'b1, i == 11, 12, 7);
      idle(1, 2, 3);
   endtask

   task automatic test_frame_sync();
      for (int i = 0; i < 6; i++)
         send(8'hFF, 8'h80, 1'b0, i / 4, i % 4, 1'b1, 1'b0, 0, 0);
      @(negedge clock);
      valid = 1'b0; frame_sync = 1'b1;
      @(posedge clock); #1;
      total += 2;
      if (frame_done !== 1'b0) begin bad++; $display("FAIL sync_frame_done got=%0b want=0", frame_done); end
      if (feature_count !== 20'(exp_fc)) begin bad++; $display("FAIL sync_feature_count got=%0d want=%0d", feature_count, exp_fc); end
      idle(1, 1, 1);
      for (int i = 0; i < 12; i++)
         send(8'(i * 16), 8'h80, 1'b0, i / 4, i % 4, i >= 8, i == 11, 4, 4);
      // frame_sync coinciding with the last pixel: no frame completes,
      // that pixel becomes (0,0) of the next frame
      for (int i = 0; i < 11; i++)
         send(8'hFF, 8'h80, 1'b0, i / 4, i % 4, 1'b1, 1'b0, 0, 0);
      send(8'hFF, 8'h80, 1'b1, 0, 0, 1'b1, 1'b0, 0, 0);
      for (int i = 1; i < 12; i++)
         send(8'hFF, 8'h80, 1'b0, i / 4, i % 4, 1'b1, i == 11, 12, 7);
      idle(1, 2, 3);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++)
         send(8'hFF, 8'h80, 1'b0, (i % 12) / 4, i % 4, 1'b1,
              (i == 11) || (i == 23), 12, 7);
      idle(1, 2, 3);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++)
         send(8'hFF, 8'h80, 1'b0, i / 4, i % 4, 1'b1, 1'b0, 0, 0);
      @(negedge clock);
      valid = 1'b0;
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clock);
      reset = 1'b0;
      exp_fc = 0; exp_fc_s = 0; last_dout = 8'h00;
      send(8'h90, 8'h80, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
      for (int i = 1; i < 12; i++)
         send(8'h00, 8'h80, 1'b0, i / 4, i % 4, 1'b0, i == 11, 1, 1);
      idle(1, 2, 3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_threshold_change();
      test_frame_sync();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/feature_mask_counter.md
Name: feature_mask_counter

Overview:
- Downstream stage of the upsampler in the check/feature pipeline, in the output-clock domain.
- Consumes the full-resolution 8-bit pixel stream (din/valid) and tracks raster position, driving the rowcount/colcount for the display path.
- Thresholds each pixel into a binary feature mask and counts feature pixels per frame.
- Publishes the count and a frame-done pulse at the end of each frame.

Parameters:
- COLS, 800, active pixels per row
- ROWS, 600, active rows per frame
- CNT_W, 20, width of feature_count; must hold COLS*ROWS or count saturates

Ports:
- clock  input  1  pipeline clock (output pixel domain)
- reset  input  1  asynchronous, active-high reset
- din  input  8  pixel from upsampler
- valid  input  1  din qualifier; one pixel per asserted cycle
- frame_sync  input  1  single-cycle pulse: resynchronise raster to (0,0)
- threshold  input  8  feature threshold, sampled per frame
- dout  output  8  mask pixel
- validout  output  1  dout qualifier
- rowcount  output  10  row of the pixel on dout
- colcount  output  10  column of the pixel on dout
- feature_count  output  CNT_W  feature pixels in last completed frame
- frame_done  output  1  one-cycle pulse when feature_count updates

Behaviour:
- Reset, asynchronous, active-high. Clears:
  - dout=0, validout=0, rowcount=0, colcount=0
  - feature_count=0, frame_done=0
  - internal row/col counters=0, running count=0, thr_q=0
  - state=IDLE
- States:
  - IDLE: waits for first valid or frame_sync.
  - ACTIVE: streaming a frame.
  - DONE: one cycle. Latch, pulse, then return to ACTIVE with counters at (0,0).
- Transitions:
  - IDLE -> ACTIVE on valid. That pixel is treated as (0,0).
  - ACTIVE -> DONE on valid at (ROWS-1, COLS-1).
  - DONE -> ACTIVE unconditionally.
  - A valid pixel arriving in DONE is processed as (0,0) of the next frame. No pixel is dropped.
- Threshold: thr_q samples threshold on the valid pixel at (0,0). It is constant for the rest of the frame; changes mid-frame take effect next frame.
- Compare: the pixel at (0,0) uses the freshly sampled threshold value, not the old thr_q.
- Pixel path: latency exactly 1 cycle.
  - validout = valid registered.
  - dout = (din >= thr) ? 8'hFF : 8'h00.
  - rowcount/colcount = position of that pixel.
  - dout, rowcount and colcount hold their last values when validout=0.
- Raster counters:
  - col increments per valid pixel and wraps at COLS-1 to 0, incrementing row.
  - row wraps at ROWS-1 to 0.
  - No change on cycles with valid low; gaps of any length are allowed.
- Counting:
  - The running count increments on each valid pixel with din >= thr.
  - It saturates at 2^CNT_W-1, with no wrap.
- End of frame: on the last pixel (ROWS-1, COLS-1), the cycle after it is accepted:
  - feature_count <= running count, including that last pixel.
  - frame_done = 1 for exactly 1 cycle.
  - The running count clears to 0.
- frame_sync:
  - Forces the counters to (0,0) and clears the running count.
  - The partial frame is discarded: no frame_done, feature_count unchanged.
  - State goes to ACTIVE. A pixel valid in the same cycle is taken as (0,0) of the new frame.
  - frame_sync at the exact last pixel takes priority: the frame is discarded and no DONE is entered.
- Reset mid-frame: all state is lost. The next valid after reset release is (0,0).

Optional Feature:
- Macro: FEATURE_OVERLAY_EN.
- Defined: below-threshold pixels pass through unchanged on dout (dout = din < thr ? din : 8'hFF). Features are painted white over the original image.
- Undefined: pure binary mask as above.
- Counting, latency and frame behaviour are identical in both builds.

Test Plan:
- Reset/basic, COLS=4, ROWS=3, threshold=8'h80, 12 consecutive valid pixels with values 0x00..0xB0 in steps of 0x10:
  - validout 1 cycle after each valid.
  - dout=0x00 for pixels 0-7, 0xFF for pixels 8-11.
  - rowcount/colcount sequence (0,0)..(2,3).
  - frame_done pulses 1 cycle after pixel 11, with feature_count=4.
- Gapped stream: same frame with valid toggled 1-on/2-off. Results are identical to the basic case; counters hold during gaps.
- Threshold change: threshold changes to 0x00 at pixel 5 of a frame.
  - That frame still reports 4.
  - The next frame (threshold 0x00 sampled at (0,0)) reports 12.
- frame_sync mid-frame: pulse after 6 pixels.
  - No frame_done; feature_count holds its previous value.
  - The next pixel reports (0,0).
  - The following full frame reports the correct count.
- Back-to-back frames: 24 consecutive valid pixels, all 0xFF, threshold 0x80.
  - Two frame_done pulses, each with feature_count=12.
  - No pixel lost at the DONE cycle.
- Saturation: CNT_W=3, frame of all 0xFF → feature_count=7. Async reset asserted mid-frame → all outputs 0 immediately.
